mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 3: cycles from request sample to memReady; legal range 1..15.
REQ-002 SHALL have parameter DEPTH, default 256: number of 16-bit words; power of two.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port resetN, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port loadMem, input, 1: load request, sampled only in IDLE.
REQ-006 SHALL have port memAddr, input, 16: load word address, captured with loadMem.
REQ-007 SHALL have port storeEn, input, 1: write strobe, honoured in every state.
REQ-008 SHALL have port storeAddr, input, 16: write word address.
REQ-009 SHALL have port storeData, input, 16: write data.
REQ-010 SHALL have port memReady, output, 1: one-cycle pulse marking memOut valid.
REQ-011 SHALL have port memOut, output, 16: load data, registered.
REQ-012 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-013 SHALL have port loadCount, output, 16: completed-load counter.

Function
REQ-014 SHALL implement states IDLE, WAIT and RESPOND.
REQ-015 SHALL, in IDLE with loadMem high at an edge, capture memAddr into an address register and load the countdown with LATENCY-1.
REQ-016 SHALL, at that same edge, go to RESPOND when LATENCY=1 and to WAIT otherwise.
REQ-017 SHALL, in WAIT, decrement the countdown each edge and go to RESPOND on the edge where it reaches 0.
REQ-018 SHALL give this timing: loadMem sampled at the end of cycle N gives memReady high for exactly cycle N+LATENCY.
REQ-019 SHALL load memOut from the array at the captured address on the edge entering RESPOND.
REQ-020 SHALL hold memOut at its last loaded value until the next load completes.
REQ-021 SHALL stay in RESPOND for exactly one cycle, then return to IDLE.
REQ-022 SHALL accept a new loadMem in the first IDLE cycle after RESPOND (back-to-back loads, one idle cycle minimum).
REQ-023 SHALL ignore loadMem in WAIT and RESPOND, with no queuing; the requester holds the request until accepted.
REQ-024 SHALL decode addresses as address modulo DEPTH (low log2(DEPTH) bits); upper bits are ignored, with no error.
REQ-025 SHALL write storeData into word storeAddr mod DEPTH on every edge where storeEn is high.
REQ-026 SHALL make a store visible to a pending load if the store edge is strictly before the edge entering RESPOND.
REQ-027 SHALL, for a store and the RESPOND-entry read to the same word on the same edge, return the old data to memOut (read-before-write).
REQ-028 SHALL increment loadCount by 1 on each edge entering RESPOND, wrapping 16'hFFFF to 0.

Reset
REQ-029 SHALL, while resetN is low, immediately force state=IDLE, memReady=0, memOut=0, busy=0, loadCount=0, countdown=0 and address register=0.
REQ-030 SHALL, on reset asserted mid-load (WAIT or RESPOND), abort the load with no memReady pulse and leave loadCount unincremented.
REQ-031 SHALL leave array contents unaffected by reset; contents are undefined until written.
REQ-032 SHALL, on the first edge after resetN deasserts, behave as IDLE, including sampling loadMem.

Verification
REQ-033 SHALL be verified by: LATENCY=3, store 16'h1234 at 5, then loadMem at 5 sampled at edge E -> memReady high exactly cycle E+3, memOut=16'h1234, loadCount=1.
REQ-034 SHALL be verified by: loads at addr 5 then addr 6 (16'hBEEF) with loadMem held high -> second accepted the IDLE cycle after RESPOND, memOut=16'hBEEF, loadCount=2, memReady pulses each 1 cycle.
REQ-035 SHALL be verified by: DEPTH=256, store 16'hAAAA at 16'h0107, load 16'h0007 -> memOut=16'hAAAA.
REQ-036 SHALL be verified by: load addr 9 (old 16'h0001), store 16'h0002 at 9 one edge before RESPOND -> 16'h0002; repeat with the store on the RESPOND edge -> 16'h0001.
REQ-037 SHALL be verified by: resetN low during WAIT -> memReady stays 0, memOut=0, busy=0, loadCount=0; stored data is still readable after reset.
REQ-038 SHALL be verified by: loadMem pulsed during WAIT to another address -> ignored, only one response for the original address.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word-load responder over a 16-bit array with an always-open store port
module mem_responder #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 256
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        loadMem,
  input  logic [15:0] memAddr,
  input  logic        storeEn,
  input  logic [15:0] storeAddr,
  input  logic [15:0] storeData,
  output logic        memReady,
  output logic [15:0] memOut,
  output logic        busy,
  output logic [15:0] loadCount
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;
  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d, raddr;
  logic [15:0]     out_q, out_d, lcnt_q, lcnt_d;
  logic            accept, enter;
  logic [15:0]     mem [DEPTH];
  logic            unused_hi;
  assign unused_hi = ^{memAddr[15:AW], storeAddr[15:AW]};
  // With LATENCY=1 the read happens on the accept edge, before addr_q holds the address
  always_comb begin
    accept  = state_q == IDLE && loadMem;
    enter   = (accept && LATENCY == 1) || (state_q == WAIT && cnt_q == 4'd1);
    raddr   = state_q == IDLE ? memAddr[AW-1:0] : addr_q;
    state_d = enter ? RESPOND : accept ? WAIT : state_q == WAIT ? WAIT : IDLE;
    cnt_d   = accept ? 4'(LATENCY - 1) : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
    addr_d  = accept ? memAddr[AW-1:0] : addr_q;
    out_d   = enter ? mem[raddr] : out_q;
    lcnt_d  = enter ? lcnt_q + 16'd1 : lcnt_q;
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      out_q   <= '0;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      out_q   <= out_d;
      lcnt_q  <= lcnt_d;
    end
  end
  // Array is deliberately outside reset; same-edge read above sees the old word
  always_ff @(posedge clk) begin
    if (storeEn) mem[storeAddr[AW-1:0]] <= storeData;
  end
  assign memReady  = state_q == RESPOND;
  assign busy      = state_q != IDLE;
  assign memOut    = out_q;
  assign loadCount = lcnt_q;
endmodule
